uart_rx_fifo: RTL and testbench

//   Receive buffer directly downstream of the UART receiver.

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind a UART receiver.
// Stores {e_frame, e_parity, din} on each rx_done_tick and presents them to
// the host as a first-word-fall-through FIFO. It also provides a sticky
// overrun flag and saturating parity/framing error counters.
// Optional build macro UART_RX_FIFO_ERR_DROP_EN: when defined, errored
// characters are only counted and are never stored.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   din,
  input  logic              e_parity,
  input  logic              e_frame,
  input  logic              rd,
  input  logic              clr_ovr,
  input  logic              clr_err,
  output logic [DBIT-1:0]   dout,
  output logic              dout_e_par,
  output logic              dout_e_frm,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic [7:0]        par_err_cnt,
  output logic [7:0]        frm_err_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int EW    = DBIT + 2;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  // Entry layout: {frame error, parity error, character}
  logic [EW-1:0]     mem [0:DEPTH-1];

  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              empty_reg, full_reg;
  logic              overrun_reg, overrun_next;
  logic              accept, push, pop, ovr_event;
  logic [1:0]        err_in;

  // Decide which characters are candidates for storage, and resolve push/pop
  always_comb begin
    accept = rx_done_tick;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    if (e_parity || e_frame)
      accept = 1'b0;
`endif
    pop       = rd && !empty_reg;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the write
    push      = accept && (!full_reg || pop);
    ovr_event = accept && full_reg && !pop;
  end

  // Next occupancy and sticky overrun (a new overrun beats a clear)
  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;

    overrun_next = overrun_reg;
    if (ovr_event)
      overrun_next = 1'b1;
    else if (clr_ovr)
      overrun_next = 1'b0;
  end

  // Pointers, count and status flags; flags come from next-count so rd has
  // no combinational path to empty/full
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg   <= count_next;
      empty_reg   <= (count_next == '0);
      full_reg    <= (count_next == DEPTH_CNT);
      overrun_reg <= overrun_next;
    end
  end

  // Storage write; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {e_frame, e_parity, din};
  end

  // Head entry is read combinationally so it is valid whenever empty=0
  assign {dout_e_frm, dout_e_par, dout} = mem[rd_ptr_reg];

  assign empty   = empty_reg;
  assign full    = full_reg;
  assign count   = count_reg;
  assign overrun = overrun_reg;

  // Index 0 counts parity errors, index 1 framing errors
  assign err_in = {e_frame, e_parity};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_err_cnt
      logic [7:0] cnt_reg;

      // Saturating error counter; clear takes priority over a same-cycle increment
      always_ff @(posedge clk) begin
        if (reset)
          cnt_reg <= '0;
        else if (clr_err)
          cnt_reg <= '0;
        else if (rx_done_tick && err_in[gi] && (cnt_reg != 8'hFF))
          cnt_reg <= cnt_reg + 8'd1;
      end
    end
  endgenerate

  assign par_err_cnt = g_err_cnt[0].cnt_reg;
  assign frm_err_cnt = g_err_cnt[1].cnt_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] din;
  logic       e_parity;
  logic       e_frame;
  logic       rd;
  logic       clr_ovr;
  logic       clr_err;
  logic [7:0] dout;
  logic       dout_e_par;
  logic       dout_e_frm;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic [7:0] par_err_cnt;
  logic [7:0] frm_err_cnt;

  uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .din          (din),
    .e_parity     (e_parity),
    .e_frame      (e_frame),
    .rd           (rd),
    .clr_ovr      (clr_ovr),
    .clr_err      (clr_err),
    .dout         (dout),
    .dout_e_par   (dout_e_par),
    .dout_e_frm   (dout_e_frm),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun),
    .par_err_cnt  (par_err_cnt),
    .frm_err_cnt  (frm_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] q[$];
  bit         m_ovr;
  int         m_par, m_frm;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [7:0] dut_last_pop;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("count",   32'(count),       32'(q.size()));
    check_val("empty",   32'(empty),       32'(q.size() == 0));
    check_val("full",    32'(full),        32'(q.size() == DEPTH));
    check_val("overrun", 32'(overrun),     32'(m_ovr));
    check_val("par_cnt", 32'(par_err_cnt), 32'(m_par));
    check_val("frm_cnt", 32'(frm_err_cnt), 32'(m_frm));
    if (q.size() > 0)
      check_val("head", 32'({dout_e_frm, dout_e_par, dout}), 32'(q[0]));
  endtask

  // One clock cycle with the given inputs; the model advances by the same
  // rules and all outputs are compared 1 time unit after the edge.
  task automatic step(input bit tick, input logic [7:0] d, input bit ep, input bit ef,
                      input bit r, input bit co, input bit ce);
    bit         was_full, was_empty, do_pop, acc;
    logic [9:0] popped;
    rx_done_tick = tick;
    din          = d;
    e_parity     = ep;
    e_frame      = ef;
    rd           = r;
    clr_ovr      = co;
    clr_err      = ce;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r && !was_empty)
      dut_last_pop = dout;
    @(posedge clk);
    do_pop = r && !was_empty;
    acc    = tick && !(DROP_ERR && (ep || ef));
    popped = '0;
    if (do_pop)
      popped = q.pop_front();
    if (acc) begin
      if (!was_full || do_pop)
        q.push_back({ef, ep, d});
      else
        m_ovr = 1'b1;
    end
    if (!(acc && was_full && !do_pop) && co)
      m_ovr = 1'b0;
    if (ce) begin
      m_par = 0;
      m_frm = 0;
    end else if (tick) begin
      if (ep && m_par < 255) m_par++;
      if (ef && m_frm < 255) m_frm++;
    end
    if (do_pop)
      $display("pop data=0x%02h par=%0d frm=%0d count=%0d", popped[7:0], popped[8], popped[9], q.size());
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_char(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_char();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_done_tick = 1'b0; din = '0; e_parity = 1'b0; e_frame = 1'b0;
    rd = 1'b0; clr_ovr = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    m_par = 0;
    m_frm = 0;
    $display("reset");
    check_all();
  endtask

  initial begin
    int pr;
    do_reset();
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full",  32'(full),  32'd0);

    // 1: three characters in order
    push_char(8'h41); push_char(8'h42); push_char(8'h43);
    check_val("t1_count", 32'(count), 32'd3);
    check_val("t1_head",  32'(dout),  32'h41);
    pop_char(); check_val("t1_pop0", 32'(dut_last_pop), 32'h41);
    pop_char(); check_val("t1_pop1", 32'(dut_last_pop), 32'h42);
    pop_char(); check_val("t1_pop2", 32'(dut_last_pop), 32'h43);
    check_val("t1_empty", 32'(empty), 32'd1);
    pop_char();  // rd while empty is harmless

    // 2: fill, overrun, clear
    for (int i = 0; i < DEPTH; i++) push_char(8'(8'h60 + i));
    check_val("t2_full",  32'(full),  32'd1);
    check_val("t2_count", 32'(count), 32'd16);
    push_char(8'hEE);
    check_val("t2_ovr",   32'(overrun), 32'd1);
    check_val("t2_cnt17", 32'(count),   32'd16);
    check_val("t2_head",  32'(dout),    32'h60);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t2_clr", 32'(overrun), 32'd0);

    // 3: simultaneous push/pop when full, then when empty
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("t3_count", 32'(count),   32'd16);
    check_val("t3_ovr",   32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_char();
    check_val("t3_last",  32'(dut_last_pop), 32'h55);
    check_val("t3_empty", 32'(empty), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("t3_cnt1", 32'(count), 32'd1);
    pop_char();

    // 4: twenty characters interleaved with pops, pointers wrap
    for (int i = 0; i < 20; i++) begin
      push_char(8'(8'h80 + i));
      if (i % 3 == 2) begin pop_char(); pop_char(); end
    end
    while (q.size() > 0) pop_char();

    // 5: errored characters
    do_reset();
    step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t5_count", 32'(count), DROP_ERR ? 32'd0 : 32'd2);
    check_val("t5_par",   32'(par_err_cnt), 32'd1);
    check_val("t5_frm",   32'(frm_err_cnt), 32'd1);
    if (!DROP_ERR) begin
      check_val("t5_hpar", 32'({dout_e_frm, dout_e_par, dout}), 32'h110);
      pop_char();
      check_val("t5_hfrm", 32'({dout_e_frm, dout_e_par, dout}), 32'h211);
      pop_char();
    end

    // 6: saturation, clear priority, mid-stream reset
    for (int i = 0; i < 300; i++)
      step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("t6_sat", 32'(par_err_cnt), 32'd255);
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("t6_clrp", 32'(par_err_cnt), 32'd0);
    check_val("t6_clrf", 32'(frm_err_cnt), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) push_char(8'(i));
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_val("t6_empty", 32'(empty),       32'd1);
    check_val("t6_ovr",   32'(overrun),     32'd0);
    check_val("t6_par",   32'(par_err_cnt), 32'd0);

    // Randomized traffic with alternating fill/drain pressure
    for (int i = 0; i < 3000; i++) begin
      pr = ((i / 150) % 2 == 0) ? 20 : 75;
      step($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 10,
           $urandom_range(99) < 10, $urandom_range(99) < pr,
           $urandom_range(99) < 5, $urandom_range(99) < 2);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
